// File: rtl/oet_sort_engine.sv
// oet_sort_engine: frame sorter using odd-even transposition on rotated keys {x[KEY_W-1:0], x[WIDTH-1:KEY_W]}.
// Define SORT_EARLY_EXIT_EN to end SORT once an even and an odd phase in a row make no swaps.
module oet_sort_engine #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int KEY_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [1:0] LOAD = 2'd0, SORT = 2'd1, DRAIN = 2'd2;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  logic [1:0] state_q, state_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, phase_q, phase_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic sort_done;
`ifdef SORT_EARLY_EXIT_EN
  logic any_swap, clean_q, clean_d;
`endif

  // Rotating right by KEY_W puts the primary key bits on top; KEY_W==WIDTH leaves x unchanged.
  function automatic logic [WIDTH-1:0] key(input logic [WIDTH-1:0] x);
    return WIDTH'({x, x} >> KEY_W);
  endfunction

  always_comb begin
    state_d = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    phase_d = phase_q;
    mem_d = mem_q;
    sort_done = phase_q == LAST;
`ifdef SORT_EARLY_EXIT_EN
    any_swap = 1'b0;
    clean_d = clean_q;
`endif
    if (state_q == LOAD && in_valid) begin
      mem_d[wr_idx_q] = in_data;
      wr_idx_d = wr_idx_q == LAST ? '0 : wr_idx_q + 1'b1;
      state_d = wr_idx_q == LAST ? SORT : LOAD;
    end
    if (state_q == SORT) begin
      // Pairs starting at indices of the phase's parity are disjoint, so all compare-swaps run in parallel.
      for (int i = 0; i < DEPTH - 1; i++)
        if (i[0] == phase_q[0] && key(mem_q[i]) > key(mem_q[i+1])) begin
          mem_d[i] = mem_q[i+1];
          mem_d[i+1] = mem_q[i];
`ifdef SORT_EARLY_EXIT_EN
          any_swap = 1'b1;
`endif
        end
`ifdef SORT_EARLY_EXIT_EN
      clean_d = !any_swap;
      sort_done = sort_done || (phase_q != '0 && !any_swap && clean_q);
`endif
      phase_d = sort_done ? '0 : phase_q + 1'b1;
      state_d = sort_done ? DRAIN : SORT;
    end
    if (state_q == DRAIN && out_ready) begin
      rd_idx_d = rd_idx_q == LAST ? '0 : rd_idx_q + 1'b1;
      state_d = rd_idx_q == LAST ? LOAD : DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      phase_q <= '0;
`ifdef SORT_EARLY_EXIT_EN
      clean_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      phase_q <= phase_d;
`ifdef SORT_EARLY_EXIT_EN
      clean_q <= clean_d;
`endif
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign in_ready = state_q == LOAD;
  assign out_valid = state_q == DRAIN;
  assign busy = state_q == SORT;
  assign out_data = out_valid ? mem_q[rd_idx_q] : '0;
  assign out_last = out_valid && rd_idx_q == LAST;
endmodule

// File: tb/tb_oet_sort_engine.sv
// tb_oet_sort_engine: randomized self-checking bench against a stable insertion-sort reference.
module tb_oet_sort_engine;
  typedef int iq_t[$];
`ifdef SORT_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_out_last, a_busy;
  logic [7:0] a_in_data = 0, a_out_data;
  logic b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_out_last, b_busy;
  logic [11:0] b_in_data = 0, b_out_data;
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  oet_sort_engine u_dut (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last), .busy(a_busy)
  );

  oet_sort_engine #(.WIDTH(12), .DEPTH(16), .KEY_W(12)) u_big (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy)
  );

  function automatic int keyf(input int x, input int w, input int kw);
    return ((x & ((1 << kw) - 1)) << (w - kw)) | (x >> kw);
  endfunction

  function automatic iq_t ref_sort(input iq_t a, input int w, input int kw);
    iq_t s;
    s = {};
    foreach (a[k]) begin
      int p;
      p = s.size();
      while (p > 0 && keyf(s[p-1], w, kw) > keyf(a[k], w, kw)) p--;
      s.insert(p, a[k]);
    end
    return s;
  endfunction

  function automatic iq_t rand_frame_a();
    iq_t f;
    f = {};
    for (int k = 0; k < 8; k++) f.push_back(int'($urandom_range(0, 255)));
    return f;
  endfunction

  task automatic pulse_rst();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic load_a(input iq_t f, input bit gaps);
    int i, g;
    logic v, acc;
    i = 0; g = 0;
    while (i < f.size() && g < 1000) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      a_in_valid = v; a_in_data = 8'(f[i]);
      acc = v && a_in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      g++;
    end
    a_in_valid = 0;
    checks++;
    if (i != f.size()) begin fails++; $display("FAIL load_a: accepted=%0d required=%0d", i, f.size()); end
  endtask

  task automatic wait_a(output int lat, output int bc);
    lat = 0; bc = 0;
    while (!a_out_valid && lat < 100) begin
      bc += int'(a_busy);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain_a(input iq_t e, input bit stalls);
    int j, g;
    logic r, fire;
    j = 0; g = 0;
    while (j < e.size() && g < 1000) begin
      r = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
      a_out_ready = r;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== 8'(e[j]) || a_out_last !== (j == e.size() - 1)) begin
        fails++;
        $display("FAIL drain_a word %0d: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                 j, a_out_valid, a_out_data, a_out_last, 8'(e[j]), j == e.size() - 1);
        break;
      end
      fire = r;
      @(posedge clk); #1;
      if (fire) j++;
      g++;
    end
    a_out_ready = 0;
    checks++;
    if (j != e.size() || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL drain_a_end: words=%0d out_valid=%b in_ready=%b required words=%0d out_valid=0 in_ready=1",
               j, a_out_valid, a_in_ready, e.size());
      pulse_rst();
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if ({a_in_ready, a_out_valid, a_out_data, a_out_last, a_busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL %s: in_ready=%b out_valid=%b out_data=%h out_last=%b busy=%b required 1 0 00 0 0",
               tag, a_in_ready, a_out_valid, a_out_data, a_out_last, a_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check_idle("reset_a");
    checks++;
    if ({b_in_ready, b_out_valid, b_out_data, b_out_last, b_busy} !== {1'b1, 1'b0, 12'h000, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_b: in_ready=%b out_valid=%b out_data=%h out_last=%b busy=%b required 1 0 000 0 0",
               b_in_ready, b_out_valid, b_out_data, b_out_last, b_busy);
    end
  endtask

  task automatic test_descending();
    int lat, bc;
    load_a('{7, 6, 5, 4, 3, 2, 1, 0}, 1'b0);
    wait_a(lat, bc);
    checks++;
    if (EE ? (lat > 8 || lat < 2) : lat != 8) begin fails++; $display("FAIL desc_latency: got=%0d required=8", lat); end
    drain_a('{0, 1, 2, 3, 4, 5, 6, 7}, 1'b0);
  endtask

  task automatic test_key();
    int lat, bc;
    load_a('{'h21, 'h10, 'h11, 'h30, 'h01, 'h20, 'h31, 'h00}, 1'b0);
    wait_a(lat, bc);
    drain_a('{'h00, 'h10, 'h20, 'h30, 'h01, 'h11, 'h21, 'h31}, 1'b1);
  endtask

  task automatic test_stable();
    int lat, bc;
    load_a('{5, 5, 5, 5, 5, 5, 5, 5}, 1'b1);
    wait_a(lat, bc);
    checks++;
    if (EE ? lat != 2 : lat != 8) begin fails++; $display("FAIL stable_latency: got=%0d required=%0d", lat, EE ? 2 : 8); end
    drain_a('{5, 5, 5, 5, 5, 5, 5, 5}, 1'b1);
  endtask

  task automatic test_mid_reset();
    iq_t f;
    int lat, bc;
    load_a('{7, 6, 5, 4, 3, 2, 1, 0}, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (a_busy !== 1'b1) begin fails++; $display("FAIL sort_phase3_busy: got=%b required=1", a_busy); end
    pulse_rst();
    check_idle("reset_in_sort");
    f = rand_frame_a();
    load_a(f, 1'b1);
    wait_a(lat, bc);
    drain_a(ref_sort(f, 8, 4), 1'b1);
    f = rand_frame_a();
    load_a(f, 1'b0);
    wait_a(lat, bc);
    a_out_ready = 1;
    repeat (3) @(posedge clk);
    #1 a_out_ready = 0;
    checks++;
    if (a_out_valid !== 1'b1) begin fails++; $display("FAIL mid_drain_valid: got=%b required=1", a_out_valid); end
    pulse_rst();
    check_idle("reset_in_drain");
    f = rand_frame_a();
    load_a(f, 1'b1);
    wait_a(lat, bc);
    drain_a(ref_sort(f, 8, 4), 1'b0);
  endtask

  task automatic test_early_exit();
    int lat, bc;
    load_a('{0, 1, 2, 3, 4, 5, 6, 7}, 1'b0);
    wait_a(lat, bc);
    checks++;
    if (bc != (EE ? 2 : 8) || lat != (EE ? 2 : 8)) begin
      fails++;
      $display("FAIL sorted_busy: busy_cycles=%0d latency=%0d required %0d", bc, lat, EE ? 2 : 8);
    end
    drain_a('{0, 1, 2, 3, 4, 5, 6, 7}, 1'b0);
  endtask

  task automatic test_random();
    iq_t f, e;
    int i, j, g, lat;
    logic v, acc, r;
    for (int n = 0; n < 200; n++) begin
      f = {};
      for (int k = 0; k < 16; k++)
        f.push_back($urandom_range(0, 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 4095)));
      e = ref_sort(f, 12, 12);
      i = 0; g = 0;
      while (i < 16 && g < 1000) begin
        v = $urandom_range(0, 3) != 0;
        b_in_valid = v; b_in_data = 12'(f[i]); b_out_ready = 1'($urandom);
        acc = v && b_in_ready;
        @(posedge clk); #1;
        if (acc) i++;
        g++;
      end
      lat = 0;
      while (!b_out_valid && lat < 100) begin
        b_in_valid = 1'($urandom); b_in_data = 12'($urandom); b_out_ready = 1'($urandom);
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (i != 16 || (EE ? (lat > 16 || lat < 2) : lat != 16)) begin
        fails++;
        $display("FAIL rand_load frame %0d: accepted=%0d latency=%0d required 16 and 16", n, i, lat);
        b_in_valid = 0; b_out_ready = 0;
        pulse_rst();
        return;
      end
      j = 0; g = 0;
      while (j < 16 && g < 1000) begin
        r = 1'($urandom);
        b_out_ready = r; b_in_valid = 1'($urandom); b_in_data = 12'($urandom);
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== 12'(e[j]) || b_out_last !== (j == 15)) begin
          fails++;
          $display("FAIL rand_drain frame %0d word %0d: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                   n, j, b_out_valid, b_out_data, b_out_last, 12'(e[j]), j == 15);
          b_in_valid = 0; b_out_ready = 0;
          pulse_rst();
          return;
        end
        @(posedge clk); #1;
        if (r) j++;
        g++;
      end
      b_in_valid = 0; b_out_ready = 0;
      checks++;
      if (j != 16 || b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
        fails++;
        $display("FAIL rand_end frame %0d: words=%0d out_valid=%b in_ready=%b required 16 0 1", n, j, b_out_valid, b_in_ready);
        pulse_rst();
        return;
      end
    end
  endtask

  initial begin
    test_reset();
    test_descending();
    test_key();
    test_stable();
    test_mid_reset();
    test_early_exit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
